iso_frame_renderer: RTL and testbench



---
 rtl/iso_frame_renderer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_iso_frame_renderer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/iso_frame_renderer.sv
// rtl/iso_frame_renderer.sv - one-pixel-per-cycle isometric block and player frame rasteriser
// Optional feature macro: DOUBLE_BUF_EN (wr_addr MSB selects the back buffer, front_buf flips at FIN).
module iso_frame_renderer #(
  parameter int PX_WIDTH   = 160,
  parameter int PX_HEIGHT  = 120,
  parameter int COLOR_W    = 3,
  parameter int N_SQ       = 4,
  parameter int BG_COLOR   = 0,
  parameter int DEAD_COLOR = 4,
  parameter int PL_COLOR   = 7,
  parameter int PL_HALF_W  = 2,
  parameter int ADDR_W     = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          dead,
  input  logic [N_SQ-1:0]               sq_valid,
  input  logic [N_SQ*(32+3*COLOR_W)-1:0] squares,
  input  logic [23:0]                   player,
  output logic                          busy,
  output logic                          done,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [COLOR_W-1:0]            wr_data,
  output logic                          front_buf
);

  localparam int SQ_W = 32 + 3*COLOR_W;
`ifdef DOUBLE_BUF_EN
  localparam int PIX_W = ADDR_W - 1;
`else
  localparam int PIX_W = ADDR_W;
`endif
  localparam logic signed [11:0] W_LIM = 12'(PX_WIDTH);
  localparam logic signed [11:0] H_LIM = 12'(PX_HEIGHT);
  localparam logic signed [11:0] HW    = 12'(PL_HALF_W);
  localparam logic signed [11:0] ONE   = 12'sd1;
  localparam logic signed [11:0] ZERO  = 12'sd0;

  typedef enum logic [2:0] {IDLE, CLEAR, SQ_TOP, SQ_LEFT, SQ_RIGHT, PLAYER, FIN} state_t;

  state_t state, state_n;
  logic signed [11:0] x, y, x_n, y_n;
  logic [3:0] sl, sl_n;

  logic                  dead_q;
  logic [N_SQ-1:0]       sq_valid_q;
  logic [N_SQ*SQ_W-1:0]  squares_q;
  logic [23:0]           player_q;

  function automatic logic signed [11:0] ext8(input logic [7:0] v);
    return $signed({4'b0000, v});
  endfunction

  // Lowest valid slot index >= from; bit 4 flags that one exists.
  function automatic logic [4:0] first_valid(input logic [N_SQ-1:0] v, input logic [3:0] from);
    logic [4:0] res;
    res = '0;
    for (int i = N_SQ-1; i >= 0; i--) begin
      if (4'(i) >= from && v[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  logic [SQ_W-1:0] cur;
  logic signed [11:0] cx, cy, r, h, px, py, ph;
  logic [COLOR_W-1:0] c1, c2, c3;
  logic [4:0] fv;
  logic signed [11:0] ncx, ncy, nr;
  logic signed [11:0] ly0, ry0;

  assign cur = squares_q[int'(sl)*SQ_W +: SQ_W];
  assign cx  = ext8(cur[7:0]);
  assign cy  = ext8(cur[15:8]);
  assign r   = ext8(cur[23:16]);
  assign h   = ext8(cur[31:24]);
  assign c1  = cur[32 +: COLOR_W];
  assign c2  = cur[32+COLOR_W +: COLOR_W];
  assign c3  = cur[32+2*COLOR_W +: COLOR_W];

  assign px = ext8(player_q[7:0]);
  assign py = ext8(player_q[15:8]);
  assign ph = ext8(player_q[23:16]);

  assign fv  = first_valid(sq_valid_q, (state == CLEAR) ? 4'd0 : sl + 4'd1);
  assign ncx = ext8(squares_q[int'(fv[3:0])*SQ_W      +: 8]);
  assign ncy = ext8(squares_q[int'(fv[3:0])*SQ_W + 8  +: 8]);
  assign nr  = ext8(squares_q[int'(fv[3:0])*SQ_W + 16 +: 8]);

  // First row of the face column at x; the left face steps down, the right face steps up.
  assign ly0 = cy + r - (cx - x) + ONE;
  assign ry0 = cy + r - (x - cx) + ONE;

  always_comb begin
    logic leave;
    state_n = state;
    x_n     = x;
    y_n     = y;
    sl_n    = sl;
    leave   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          x_n     = ZERO;
          y_n     = ZERO;
        end
      end
      CLEAR: begin
        if (x == W_LIM - ONE) begin
          x_n = ZERO;
          if (y == H_LIM - ONE) leave = 1'b1;
          else                  y_n = y + ONE;
        end else begin
          x_n = x + ONE;
        end
      end
      SQ_TOP: begin
        if (x == cx + r) begin
          x_n = cx - r;
          if (y == cy + r) begin
            if (h != ZERO) begin
              state_n = SQ_LEFT;
              y_n     = cy + ONE;
            end else begin
              leave = 1'b1;
            end
          end else begin
            y_n = y + ONE;
          end
        end else begin
          x_n = x + ONE;
        end
      end
      SQ_LEFT: begin
        if (y == ly0 + h - ONE) begin
          if (x == cx) begin
            if (r != ZERO) begin
              state_n = SQ_RIGHT;
              x_n     = cx + ONE;
              y_n     = cy + r;
            end else begin
              leave = 1'b1;
            end
          end else begin
            x_n = x + ONE;
            y_n = ly0 + ONE;
          end
        end else begin
          y_n = y + ONE;
        end
      end
      SQ_RIGHT: begin
        if (y == ry0 + h - ONE) begin
          if (x == cx + r) begin
            leave = 1'b1;
          end else begin
            x_n = x + ONE;
            y_n = ry0 - ONE;
          end
        end else begin
          y_n = y + ONE;
        end
      end
      PLAYER: begin
        if (y == py - ph + ONE) begin
          if (x == px + HW) begin
            state_n = FIN;
          end else begin
            x_n = x + ONE;
            y_n = py;
          end
        end else begin
          y_n = y - ONE;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Invalid slots and an empty player bar are skipped without spending a cycle.
    if (leave) begin
      if (fv[4]) begin
        state_n = SQ_TOP;
        sl_n    = fv[3:0];
        x_n     = ncx - nr;
        y_n     = ncy - nr;
      end else if (ph != ZERO) begin
        state_n = PLAYER;
        x_n     = px - HW;
        y_n     = py;
      end else begin
        state_n = FIN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= ZERO;
      y          <= ZERO;
      sl         <= '0;
      dead_q     <= 1'b0;
      sq_valid_q <= '0;
      squares_q  <= '0;
      player_q   <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      sl    <= sl_n;
      if (state == IDLE && start) begin
        dead_q     <= dead;
        sq_valid_q <= sq_valid;
        squares_q  <= squares;
        player_q   <= player;
      end
    end
  end

  logic drawing, in_bounds, in_diamond;
  logic signed [11:0] dx, dy, adx, ady;
  logic [PIX_W-1:0] pix;
  logic [COLOR_W-1:0] color;

  assign dx         = x - cx;
  assign dy         = y - cy;
  assign adx        = dx[11] ? -dx : dx;
  assign ady        = dy[11] ? -dy : dy;
  assign in_diamond = (adx + ady) <= r;
  assign in_bounds  = (x >= ZERO) && (x < W_LIM) && (y >= ZERO) && (y < H_LIM);
  assign drawing    = (state != IDLE) && (state != FIN);
  assign pix        = PIX_W'(unsigned'(y)) * PIX_W'(PX_WIDTH) + PIX_W'(unsigned'(x));

  always_comb begin
    color = '0;
    case (state)
      CLEAR:    color = dead_q ? COLOR_W'(DEAD_COLOR) : COLOR_W'(BG_COLOR);
      SQ_TOP:   color = c1;
      SQ_LEFT:  color = c2;
      SQ_RIGHT: color = c3;
      PLAYER:   color = COLOR_W'(PL_COLOR);
      default:  color = '0;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign wr_en   = drawing && in_bounds && ((state != SQ_TOP) || in_diamond);
  assign wr_data = drawing ? color : '0;

`ifdef DOUBLE_BUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            front_buf <= 1'b0;
    else if (state == FIN) front_buf <= ~front_buf;
  end
  assign wr_addr = drawing ? {~front_buf, pix} : '0;
`else
  assign front_buf = 1'b0;
  assign wr_addr   = drawing ? pix : '0;
`endif

endmodule

// File: tb/tb_iso_frame_renderer.sv
// tb/tb_iso_frame_renderer.sv - directed self-checking bench for iso_frame_renderer
module tb_iso_frame_renderer;
  localparam int W = 16, H = 16, N = 1, C = 3, AW = 9, SQW = 32 + 3*C;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, dead = 1'b0;
  logic [N-1:0]   sq_valid = '0;
  logic [SQW-1:0] squares  = '0;
  logic [23:0]    player   = '0;
  logic busy, done, wr_en, front_buf;
  logic [AW-1:0] wr_addr;
  logic [C-1:0]  wr_data;

  always #5 clk = ~clk;

  iso_frame_renderer #(
    .PX_WIDTH(W), .PX_HEIGHT(H), .COLOR_W(C), .N_SQ(N), .BG_COLOR(0),
    .DEAD_COLOR(4), .PL_COLOR(7), .PL_HALF_W(2), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dead(dead), .sq_valid(sq_valid),
    .squares(squares), .player(player), .busy(busy), .done(done), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .front_buf(front_buf)
  );

  int tests = 0, fails = 0;
  int w_addr[$], w_data[$], w_cyc[$];
  int done_cyc, busy_cnt;

  function automatic logic [SQW-1:0] pack(int cx, int cy, int r, int h, int c1, int c2, int c3);
    return {3'(c3), 3'(c2), 3'(c1), 8'(h), 8'(r), 8'(cy), 8'(cx)};
  endfunction

  function automatic int count_data(int d);
    int n = 0;
    foreach (w_data[i]) if (w_data[i] == d) n++;
    return n;
  endfunction

  function automatic int first_idx(int d);
    foreach (w_data[i]) if (w_data[i] == d) return i;
    return 0;
  endfunction

  // Cycle 1 is the first busy cycle; returns at the negedge of the done cycle.
  task automatic run_frame(input bit perturb);
    int cyc;
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    done_cyc = -1; busy_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (busy) busy_cnt++;
      if (wr_en) begin
        w_addr.push_back(int'(wr_addr)); w_data.push_back(int'(wr_data)); w_cyc.push_back(cyc);
      end
      if (done) begin done_cyc = cyc; break; end
      if (perturb && cyc == 10) begin squares = pack(1, 1, 5, 5, 6, 6, 6); start = 1'b1; end
      if (perturb && cyc == 11) start = 1'b0;
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, wr_en, front_buf} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, wr_en, front_buf});
    end
    tests++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      fails++; $display("FAIL reset_bus: got addr=%0d data=%0d expected 0/0", wr_addr, wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clear(input bit d, input int col);
    int bad = 0;
    dead = d; sq_valid = '0; player = '0;
    run_frame(1'b0);
    dead = 1'b0;
    tests++;
    if (done_cyc !== 257) begin fails++; $display("FAIL clear%0d_done: got %0d expected 257", d, done_cyc); end
    tests++;
    if (busy_cnt !== 257) begin fails++; $display("FAIL clear%0d_busy: got %0d expected 257", d, busy_cnt); end
    tests++;
    if (w_addr.size() !== 256) begin fails++; $display("FAIL clear%0d_writes: got %0d expected 256", d, w_addr.size()); end
    foreach (w_addr[i]) if (w_addr[i] != i || w_data[i] != col || w_cyc[i] != i + 1) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL clear%0d_raster: got %0d bad writes expected 0", d, bad); end
  endtask

  task automatic check_block(input string tag);
    int i, outside = 0;
    tests++;
    if (done_cyc !== 297) begin fails++; $display("FAIL %s_done: got %0d expected 297", tag, done_cyc); end
    tests++;
    if (count_data(1) !== 13) begin fails++; $display("FAIL %s_top_cnt: got %0d expected 13", tag, count_data(1)); end
    foreach (w_data[k]) if (w_data[k] == 1 && (w_cyc[k] < 257 || w_cyc[k] > 281)) outside++;
    tests++;
    if (outside !== 0) begin fails++; $display("FAIL %s_top_win: got %0d outside expected 0", tag, outside); end
    i = first_idx(1);
    tests++;
    if (w_addr[i] !== 104 || w_cyc[i] !== 259) begin
      fails++; $display("FAIL %s_top_first: got addr=%0d cyc=%0d expected 104/259", tag, w_addr[i], w_cyc[i]);
    end
    tests++;
    if (count_data(2) !== 9) begin fails++; $display("FAIL %s_left_cnt: got %0d expected 9", tag, count_data(2)); end
    i = first_idx(2);
    tests++;
    if (w_addr[i] !== 150 || w_cyc[i] !== 282) begin
      fails++; $display("FAIL %s_left_first: got addr=%0d cyc=%0d expected 150/282", tag, w_addr[i], w_cyc[i]);
    end
    tests++;
    if (count_data(3) !== 6) begin fails++; $display("FAIL %s_right_cnt: got %0d expected 6", tag, count_data(3)); end
    i = first_idx(3);
    tests++;
    if (w_addr[i] !== 169 || w_cyc[i] !== 291) begin
      fails++; $display("FAIL %s_right_first: got addr=%0d cyc=%0d expected 169/291", tag, w_addr[i], w_cyc[i]);
    end
  endtask

  task automatic test_block;
    sq_valid = 1'b1; player = '0; squares = pack(8, 8, 2, 3, 1, 2, 3);
    run_frame(1'b0);
    check_block("block");
  endtask

  task automatic test_corner_clip;
    int i;
    sq_valid = 1'b1; player = '0; squares = pack(0, 0, 2, 0, 1, 2, 3);
    run_frame(1'b0);
    tests++;
    if (done_cyc !== 282) begin fails++; $display("FAIL corner_done: got %0d expected 282", done_cyc); end
    tests++;
    if (count_data(1) !== 6 || count_data(2) !== 0) begin
      fails++; $display("FAIL corner_cnt: got c1=%0d c2=%0d expected 6/0", count_data(1), count_data(2));
    end
    i = first_idx(1);
    tests++;
    if (w_addr[i] !== 0 || w_cyc[i] !== 269 || w_addr[w_addr.size()-1] !== 32) begin
      fails++; $display("FAIL corner_order: got first=%0d@%0d last=%0d expected 0@269 last 32",
                        w_addr[i], w_cyc[i], w_addr[w_addr.size()-1]);
    end
  endtask

  task automatic test_player;
    int i, n;
    sq_valid = '0; player = {8'd4, 8'd10, 8'd5};
    run_frame(1'b0);
    player = '0;
    n = w_addr.size();
    tests++;
    if (done_cyc !== 277) begin fails++; $display("FAIL player_done: got %0d expected 277", done_cyc); end
    tests++;
    if (count_data(7) !== 20) begin fails++; $display("FAIL player_cnt: got %0d expected 20", count_data(7)); end
    i = first_idx(7);
    tests++;
    if (w_addr[i] !== 163 || w_cyc[i] !== 257 || w_addr[i+1] !== 147) begin
      fails++; $display("FAIL player_first: got %0d@%0d then %0d expected 163@257 then 147",
                        w_addr[i], w_cyc[i], w_addr[i+1]);
    end
    tests++;
    if (w_addr[n-1] !== 119 || w_cyc[n-1] !== 276) begin
      fails++; $display("FAIL player_last: got %0d@%0d expected 119@276", w_addr[n-1], w_cyc[n-1]);
    end
  endtask

  task automatic test_snapshot;
    int rose = 0;
    sq_valid = 1'b1; player = '0; squares = pack(8, 8, 2, 3, 1, 2, 3);
    run_frame(1'b1);
    check_block("snap");
    tests++;
    if (count_data(6) !== 0) begin fails++; $display("FAIL snap_leak: got %0d writes of 6 expected 0", count_data(6)); end
    repeat (20) begin @(negedge clk); if (busy) rose++; end
    tests++;
    if (rose !== 0) begin fails++; $display("FAIL snap_requeue: got %0d busy cycles expected 0", rose); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    sq_valid = '0; player = '0;
    run_frame(1'b0);
    start = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_fin_start: got busy=%b expected 0", busy); end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    cyc = 1;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    tests++;
    if (!done || cyc !== 257) begin fails++; $display("FAIL b2b_done: got %0d expected 257", cyc); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int seen = 0;
    sq_valid = '0; player = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      fails++; $display("FAIL abort_async: got busy=%b wr_en=%b expected 0/0", busy, wr_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) begin @(negedge clk); if (done || busy) seen++; end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL abort_quiet: got %0d busy/done cycles expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_clear(1'b0, 0);
    test_clear(1'b1, 4);
    test_block();
    test_corner_clip();
    test_player();
    test_snapshot();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
